// File: rtl/ieee_754_stream_tx_if.sv
// Buffer-write and stream-out signal bundle for ieee_754_stream_tx.
// The master drives writes, start and ready_in; the slave returns the stream.
interface ieee_754_stream_tx_if #(
    parameter int N = 4
) ();
    localparam int AW = $clog2(N);

    logic          wr_en;
    logic [AW-1:0] wr_addr;
    logic [31:0]   wr_data;
    logic          start;
    logic          ready_in;
    logic          valid_out;
    logic [31:0]   data_out;
    logic [AW-1:0] index_out;
    logic          last_out;
    logic          busy;
    logic          done;

    modport master (
        output wr_en, wr_addr, wr_data, start, ready_in,
        input  valid_out, data_out, index_out, last_out, busy, done
    );

    modport slave (
        input  wr_en, wr_addr, wr_data, start, ready_in,
        output valid_out, data_out, index_out, last_out, busy, done
    );
endinterface

// File: rtl/ieee_754_stream_tx.sv
// Buffers N IEEE-754 words and streams them out over a valid/ready port.
// Define IEEE754_NAN_FILTER_EN to replace NaN words with -inf on the output.

// One buffer word; cleared by reset, loaded only when its write enable is high.
module ieee_754_stream_tx_entry (
    input  logic        clk,
    input  logic        rst,
    input  logic        we,
    input  logic [31:0] d,
    output logic [31:0] q
);
    always_ff @(posedge clk or negedge rst) begin
        if (!rst)    q <= '0;
        else if (we) q <= d;
    end
endmodule

module ieee_754_stream_tx #(
    parameter int N = 4
) (
    input  logic clk,
    input  logic rst,
    ieee_754_stream_tx_if.slave bus
);
    localparam int            AW       = $clog2(N);
    localparam logic [AW-1:0] LAST_IDX = AW'(N - 1);
    localparam logic [AW:0]   N_EXT    = (AW+1)'(N);

    typedef enum logic [1:0] {IDLE, SEND, DONE} state_t;

    state_t                 state_q, state_d;
    logic [AW-1:0]          idx_q, idx_d;
    logic [N-1:0][31:0]     buf_q;
    logic                   wr_fire;
    logic [31:0]            raw_word;
    logic [31:0]            out_word;

    // Buffer is writable only in IDLE, so it stays frozen for the whole stream.
    assign wr_fire = (state_q == IDLE) && bus.wr_en && ({1'b0, bus.wr_addr} < N_EXT);

    for (genvar i = 0; i < N; i++) begin : g_ent
        ieee_754_stream_tx_entry u_ent (
            .clk (clk),
            .rst (rst),
            .we  (wr_fire && (bus.wr_addr == AW'(i))),
            .d   (bus.wr_data),
            .q   (buf_q[i])
        );
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            idx_q   <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
        end
    end

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        unique case (state_q)
            IDLE: begin
                if (bus.start) begin
                    state_d = SEND;
                    idx_d   = '0;
                end
            end
            SEND: begin
                if (bus.ready_in) begin
                    if (idx_q == LAST_IDX) begin
                        state_d = DONE;
                        idx_d   = '0;
                    end else begin
                        idx_d = idx_q + AW'(1);
                    end
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Output is read straight from the buffer, so a write committed on the
    // start edge is already visible in the first word (write-through).
    assign raw_word = buf_q[idx_q];

`ifdef IEEE754_NAN_FILTER_EN
    assign out_word = ((raw_word[30:23] == 8'hFF) && (raw_word[22:0] != 23'd0))
                      ? 32'hFF80_0000 : raw_word;
`else
    assign out_word = raw_word;
`endif

    assign bus.valid_out = (state_q == SEND);
    assign bus.data_out  = bus.valid_out ? out_word : 32'h0;
    assign bus.index_out = idx_q;
    assign bus.last_out  = bus.valid_out && (idx_q == LAST_IDX);
    assign bus.busy      = (state_q != IDLE);
    assign bus.done      = (state_q == DONE);
endmodule

// File: tb/tb_ieee_754_stream_tx.sv
// Self-checking bench for ieee_754_stream_tx: table vectors plus corner sequences.
module tb_ieee_754_stream_tx;
`ifdef IEEE754_NAN_FILTER_EN
    localparam bit FILT = 1'b1;
`else
    localparam bit FILT = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    ieee_754_stream_tx_if #(.N(4)) bus4 ();
    ieee_754_stream_tx_if #(.N(5)) bus5 ();

    ieee_754_stream_tx #(.N(4)) dut4 (.clk(clk), .rst(rst), .bus(bus4));
    ieee_754_stream_tx #(.N(5)) dut5 (.clk(clk), .rst(rst), .bus(bus5));

    typedef struct packed {
        logic [31:0] data;
        logic [7:0]  idx;
        logic        last;
    } beat_t;

    typedef struct {
        logic [31:0] w [4];
        logic [31:0] e [4];
    } vec_t;

    beat_t sb4 [$];
    beat_t sb5 [$];
    beat_t mb4, mb5;
    vec_t  tbl [4];
    int    checks = 0;
    int    errors = 0;
    int    done_cnt = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    always @(negedge clk) begin
        if (bus4.done) done_cnt++;
        if (bus4.valid_out && bus4.ready_in) begin
            if (sb4.size() == 0) begin
                checks++; errors++;
                $display("FAIL beat4_unexpected: got %h expected no beat", bus4.data_out);
            end else begin
                mb4 = sb4.pop_front();
                chk("beat4_data", bus4.data_out, mb4.data);
                chk("beat4_index", 32'(bus4.index_out), 32'(mb4.idx));
                chk("beat4_last", 32'(bus4.last_out), 32'(mb4.last));
            end
        end
        if (bus5.valid_out && bus5.ready_in) begin
            if (sb5.size() == 0) begin
                checks++; errors++;
                $display("FAIL beat5_unexpected: got %h expected no beat", bus5.data_out);
            end else begin
                mb5 = sb5.pop_front();
                chk("beat5_data", bus5.data_out, mb5.data);
                chk("beat5_index", 32'(bus5.index_out), 32'(mb5.idx));
                chk("beat5_last", 32'(bus5.last_out), 32'(mb5.last));
            end
        end
    end

    task automatic wr4(input int a, input logic [31:0] d);
        bus4.wr_en = 1'b1; bus4.wr_addr = 2'(a); bus4.wr_data = d;
        tick();
        bus4.wr_en = 1'b0;
    endtask

    task automatic push4(input logic [31:0] e [4]);
        for (int k = 0; k < 4; k++) sb4.push_back('{e[k], 8'(k), (k == 3)});
    endtask

    // Counts cycles from the start-sampling edge until done is seen.
    task automatic wait_done4(inout int cyc);
        while (!bus4.done && cyc < 100) begin
            tick();
            cyc++;
        end
        if (!bus4.done) begin
            checks++; errors++;
            $display("FAIL done4_timeout: got no done expected done within 100 cycles");
        end
    endtask

    task automatic stream4(input string nm, input logic [31:0] e [4]);
        int cyc;
        push4(e);
        bus4.start = 1'b1;
        tick();
        bus4.start = 1'b0;
        cyc = 1;
        wait_done4(cyc);
        chk({nm, "_done_cycles"}, 32'(cyc), 32'd5);
        tick();
        chk({nm, "_done_width"}, 32'(bus4.done), 32'd0);
        chk({nm, "_idle_busy"}, 32'(bus4.busy), 32'd0);
        chk({nm, "_sb_empty"}, 32'(sb4.size()), 32'd0);
    endtask

    initial begin
        logic [31:0] v0 [4];
        logic [31:0] v1 [4];
        logic [31:0] zz [4];
        int cyc, d0;

        v0 = '{32'hC060_0000, 32'h4000_0000, 32'h40F0_0000, 32'hBF99_999A};
        v1 = '{32'h3F80_0000, 32'h4000_0000, 32'h40F0_0000, 32'hBF99_999A};
        zz = '{32'h0, 32'h0, 32'h0, 32'h0};
        tbl[0].w = v0;
        tbl[0].e = v0;
        tbl[1].w = '{32'h0000_0000, 32'h8000_0000, 32'h7F80_0000, 32'hFF80_0000};
        tbl[1].e = '{32'h0000_0000, 32'h8000_0000, 32'h7F80_0000, 32'hFF80_0000};
        tbl[2].w = '{32'h7FC0_0000, 32'h3F80_0000, 32'hFFC0_0001, 32'h7F80_0001};
        if (FILT) tbl[2].e = '{32'hFF80_0000, 32'h3F80_0000, 32'hFF80_0000, 32'hFF80_0000};
        else      tbl[2].e = '{32'h7FC0_0000, 32'h3F80_0000, 32'hFFC0_0001, 32'h7F80_0001};
        tbl[3].w = '{32'h0000_0001, 32'h807F_FFFF, 32'h7F7F_FFFF, 32'h1234_5678};
        tbl[3].e = '{32'h0000_0001, 32'h807F_FFFF, 32'h7F7F_FFFF, 32'h1234_5678};

        bus4.wr_en = 0; bus4.wr_addr = '0; bus4.wr_data = '0; bus4.start = 0; bus4.ready_in = 1;
        bus5.wr_en = 0; bus5.wr_addr = '0; bus5.wr_data = '0; bus5.start = 0; bus5.ready_in = 1;

        #1;
        chk("rst_valid", 32'(bus4.valid_out), 32'd0);
        chk("rst_data", bus4.data_out, 32'd0);
        chk("rst_index", 32'(bus4.index_out), 32'd0);
        chk("rst_last", 32'(bus4.last_out), 32'd0);
        chk("rst_busy", 32'(bus4.busy), 32'd0);
        chk("rst_done", 32'(bus4.done), 32'd0);
        tick(); tick();
        rst = 1'b1;
        tick();

        for (int i = 0; i < 4; i++) begin
            for (int k = 0; k < 4; k++) wr4(k, tbl[i].w[k]);
            stream4($sformatf("vec%0d", i), tbl[i].e);
        end

        // Stall three cycles while index 1 is presented.
        for (int k = 0; k < 4; k++) wr4(k, v0[k]);
        push4(v0);
        bus4.start = 1'b1;
        tick();
        bus4.start = 1'b0;
        tick();
        bus4.ready_in = 1'b0;
        for (int s = 0; s < 3; s++) begin
            chk("stall_data", bus4.data_out, 32'h4000_0000);
            chk("stall_index", 32'(bus4.index_out), 32'd1);
            chk("stall_valid", 32'(bus4.valid_out), 32'd1);
            tick();
        end
        bus4.ready_in = 1'b1;
        cyc = 5;
        wait_done4(cyc);
        chk("stall_done_cycles", 32'(cyc), 32'd8);
        tick();
        chk("stall_sb_empty", 32'(sb4.size()), 32'd0);

        // Write-through on the start edge, extra start pulses while busy.
        d0 = done_cnt;
        push4(v1);
        bus4.wr_en = 1'b1; bus4.wr_addr = 2'd0; bus4.wr_data = 32'h3F80_0000; bus4.start = 1'b1;
        tick();
        bus4.wr_en = 1'b0;
        cyc = 1;
        while (!bus4.done && cyc < 100) begin
            bus4.start = cyc[0];
            tick();
            cyc++;
        end
        bus4.start = 1'b1;
        tick();
        bus4.start = 1'b0;
        for (int s = 0; s < 6; s++) begin
            chk("busy_start_no_restream", 32'(bus4.valid_out), 32'd0);
            tick();
        end
        chk("busy_start_done_count", 32'(done_cnt - d0), 32'd1);
        chk("busy_start_sb_empty", 32'(sb4.size()), 32'd0);

        // Writes during SEND and DONE must not touch the buffer.
        push4(v1);
        bus4.start = 1'b1;
        tick();
        bus4.start = 1'b0;
        bus4.wr_en = 1'b1; bus4.wr_addr = 2'd2; bus4.wr_data = 32'hDEAD_BEEF;
        tick();
        bus4.wr_en = 1'b0;
        cyc = 2;
        wait_done4(cyc);
        bus4.wr_en = 1'b1; bus4.wr_addr = 2'd3; bus4.wr_data = 32'hCAFE_BABE;
        tick();
        bus4.wr_en = 1'b0;
        stream4("frozen_restream", v1);

        // Reset while index 2 is presented.
        push4(v1);
        bus4.start = 1'b1;
        tick();
        bus4.start = 1'b0;
        tick(); tick();
        chk("pre_rst_index", 32'(bus4.index_out), 32'd2);
        d0 = done_cnt;
        rst = 1'b0;
        #1;
        chk("abort_valid", 32'(bus4.valid_out), 32'd0);
        chk("abort_data", bus4.data_out, 32'd0);
        chk("abort_index", 32'(bus4.index_out), 32'd0);
        chk("abort_last", 32'(bus4.last_out), 32'd0);
        chk("abort_busy", 32'(bus4.busy), 32'd0);
        chk("abort_done", 32'(bus4.done), 32'd0);
        sb4.delete();
        tick(); tick();
        rst = 1'b1;
        tick(); tick(); tick();
        chk("abort_no_done", 32'(done_cnt - d0), 32'd0);
        stream4("post_rst_zero", zz);

        // Out-of-range writes on an N=5 instance (addresses 5..7 exist on the bus).
        for (int k = 0; k < 5; k++) begin
            bus5.wr_en = 1'b1; bus5.wr_addr = 3'(k); bus5.wr_data = 32'h1111_1111 * (k + 1);
            tick();
        end
        for (int k = 5; k < 8; k++) begin
            bus5.wr_en = 1'b1; bus5.wr_addr = 3'(k); bus5.wr_data = 32'hDEAD_BEEF;
            tick();
        end
        bus5.wr_en = 1'b0;
        for (int k = 0; k < 5; k++) sb5.push_back('{32'h1111_1111 * (k + 1), 8'(k), (k == 4)});
        bus5.start = 1'b1;
        tick();
        bus5.start = 1'b0;
        cyc = 1;
        while (!bus5.done && cyc < 100) begin
            tick();
            cyc++;
        end
        chk("n5_done_cycles", 32'(cyc), 32'd6);
        tick();
        chk("n5_sb_empty", 32'(sb5.size()), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got no finish expected finish before 200000");
        $fatal(1, "timeout");
    end
endmodule

// File: doc/ieee_754_stream_tx.md
IEEE_754_STREAM_TX -- requirements
Module: ieee_754_stream_tx

Interface
REQ-001 Parameter N, default 4: number of IEEE-754 single-precision words per vector; legal range 2..256.
REQ-002 Derived width AW = clog2(N); used for wr_addr and index_out.
REQ-003 clk  input  1  sole clock; all state changes on its rising edge.
REQ-004 rst  input  1  asynchronous, active-low reset: asserting low resets immediately; release is sampled on clk.
REQ-005 wr_en  input  1  buffer write strobe.
REQ-006 wr_addr  input  AW  buffer write index.
REQ-007 wr_data  input  32  IEEE-754 word to store.
REQ-008 start  input  1  single-cycle request to stream the buffered vector.
REQ-009 ready_in  input  1  downstream ready; a transfer occurs on a cycle with valid_out && ready_in.
REQ-010 valid_out  output  1  data_out holds a valid word.
REQ-011 data_out  output  32  streamed word, entry index_out of the buffer.
REQ-012 index_out  output  AW  buffer index of the current data_out.
REQ-013 last_out  output  1  high with valid_out when index_out == N-1.
REQ-014 busy  output  1  high in SEND and DONE.
REQ-015 done  output  1  one-cycle pulse after the final transfer.

Function
REQ-016 The block SHALL hold an N x 32 buffer and implement states IDLE, SEND and DONE.
REQ-017 IDLE: a write with wr_en=1 and wr_addr<N SHALL store wr_data; a write with wr_addr>=N SHALL be ignored.
REQ-018 SEND and DONE: wr_en SHALL be ignored, and buffer contents SHALL remain frozen.
REQ-019 IDLE with start=1 at edge t: the block SHALL enter SEND and drive valid_out=1, index_out=0, data_out=buffer[0] from edge t.
REQ-020 Simultaneous wr_en and start in IDLE: the write SHALL commit, and if wr_addr==0 the first data_out SHALL equal that wr_data (write-through).
REQ-021 start SHALL be ignored while busy=1.
REQ-022 In SEND, while valid_out && !ready_in, data_out, index_out and last_out SHALL hold stable.
REQ-023 In SEND, a transfer at index i<N-1 SHALL advance to i+1 on the next edge, with no bubble cycle.
REQ-024 Transfer at index N-1: the next edge SHALL enter DONE with valid_out=0 and done=1 for exactly one cycle; the following edge SHALL return to IDLE.
REQ-025 Full-rate case (ready_in held high): N consecutive valid cycles SHALL be produced, and done SHALL be asserted N+1 cycles after start.
REQ-026 ready_in SHALL have no effect while valid_out=0.
REQ-027 Data SHALL pass unmodified except as stated under Configuration; no arithmetic SHALL be performed on the words.

Reset
REQ-028 On rst low, the block SHALL enter IDLE immediately and drive valid_out, data_out, index_out, last_out, busy and done to 0.
REQ-029 Reset SHALL clear every buffer entry to 32'h00000000.
REQ-030 Reset during SEND SHALL abort the stream with no done pulse; the first stream after release SHALL start at index 0.

Configuration
REQ-031 Macro IEEE754_NAN_FILTER_EN selects NaN filtering on the output.
REQ-032 With IEEE754_NAN_FILTER_EN defined: any word with exponent 8'hFF and nonzero mantissa SHALL be emitted as 32'hFF800000 (-inf), so a downstream max search ignores NaNs.
REQ-033 With IEEE754_NAN_FILTER_EN undefined: NaN words SHALL pass bit-exact, with no added logic or latency.

Verification
REQ-034 Write C0600000, 40000000, 40F00000, BF99999A to indices 0..3; start with ready_in=1 -> four consecutive valid words in that order, last_out only on BF99999A, done 5 cycles after start.
REQ-035 Same vector with ready_in low for 3 cycles during index 1 -> data_out holds 40000000 for all 3 stall cycles; sequence and count unchanged.
REQ-036 start at the same edge as a write of 3F800000 to index 0 -> first data_out = 3F800000; start pulses while busy -> exactly one stream produced.
REQ-037 Write to index 2 during SEND, then a second start -> second stream identical to the first; out-of-range wr_addr in IDLE -> no entry changes.
REQ-038 rst low at index 2 -> outputs 0 immediately and no done pulse; after release, a new start streams from index 0 and the buffer reads all zeros.
REQ-039 Buffer entry 7FC00000 -> emitted as FF800000 with IEEE754_NAN_FILTER_EN defined, and as 7FC00000 without it.
